// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch sequencer: state encoding, strobe bundle
// and the width helper used to size the wait counter and IR byte index.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PC2MAR  = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_MEM2IR  = 3'd3,
        ST_DONE    = 3'd4,
        ST_JUMP    = 3'd5,
        ST_JDONE   = 3'd6
    } state_e;

    typedef struct packed {
        logic pc_cs;
        logic pc_oe;
        logic pc_we;
        logic pc_cnt_en;
        logic mar_cs;
        logic mar_we;
        logic mem_cs;
        logic mem_oe;
        logic ir_cs;
        logic ir_we;
        logic opr_oe;
        logic fetch_done;
        logic jump_done;
    } strobes_t;

    localparam strobes_t STROBES_OFF = 13'b0;

    // $clog2 that never collapses to a zero-width vector
    function automatic int unsigned width_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/fetch_sequencer_checker.sv
// Property checker for fetch_sequencer outputs: bus ownership, PC strobe exclusion,
// quiet strobes when idle or stalled, and single-cycle done pulses.
module fetch_sequencer_checker (
    input logic clk,
    input logic reset,
    input logic stall,
    input logic pc_cs,
    input logic pc_oe,
    input logic pc_we,
    input logic pc_cnt_en,
    input logic mar_cs,
    input logic mar_we,
    input logic mem_cs,
    input logic mem_oe,
    input logic ir_cs,
    input logic ir_we,
    input logic opr_oe,
    input logic busy,
    input logic fetch_done,
    input logic jump_done
);

    logic any_strobe_s;
    assign any_strobe_s = pc_cs | pc_oe | pc_we | pc_cnt_en | mar_cs | mar_we |
                          mem_cs | mem_oe | ir_cs | ir_we | opr_oe;

    a_one_driver: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({pc_oe, mem_oe, opr_oe}));

    a_we_cnt_excl: assert property (@(posedge clk) disable iff (!reset)
        !(pc_we && pc_cnt_en));

    a_idle_quiet: assert property (@(posedge clk) disable iff (!reset)
        !busy |-> !(any_strobe_s || fetch_done || jump_done));

    a_stall_quiet: assert property (@(posedge clk) disable iff (!reset)
        stall |-> !(any_strobe_s || fetch_done || jump_done));

    a_fetch_pulse: assert property (@(posedge clk) disable iff (!reset)
        fetch_done |=> !fetch_done);

    a_jump_pulse: assert property (@(posedge clk) disable iff (!reset)
        jump_done |=> !jump_done);

    a_done_busy: assert property (@(posedge clk) disable iff (!reset)
        (fetch_done || jump_done) |-> busy);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / PC-load control FSM. Drives Moore-decoded strobes for the PC
// counter, MAR, memory and IR on a shared tri-state bus; owns no data path.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = `DATA_WIDTH,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned IR_BYTES    = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fetch_req,
    input  logic                               jump_req,
    input  logic                               stall,
    output logic                               pc_cs,
    output logic                               pc_oe,
    output logic                               pc_we,
    output logic                               pc_cnt_en,
    output logic                               mar_cs,
    output logic                               mar_we,
    output logic                               mem_cs,
    output logic                               mem_oe,
    output logic                               ir_cs,
    output logic                               ir_we,
    output logic [width_min1(IR_BYTES)-1:0]    ir_sel,
    output logic                               opr_oe,
    output logic                               busy,
    output logic                               fetch_done,
    output logic                               jump_done
);

    localparam int unsigned      CNT_W    = width_min1(WAIT_CYCLES + 32'd1);
    localparam int unsigned      IDX_W    = width_min1(IR_BYTES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IR_BYTES - 32'd1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(32'd0);

    if (IR_BYTES < 32'd1 || DATA_WIDTH < 32'd1) begin : g_bad_params
        $error("fetch_sequencer: IR_BYTES and DATA_WIDTH must be at least 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    strobes_t         strb_s;
    logic [IDX_W-1:0] sel_s;

    // State, wait counter and byte index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; a stall outside IDLE freezes state, counter and index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (state_q == ST_IDLE) begin
            if (jump_req) begin
                state_d = ST_JUMP;
            end else if (fetch_req) begin
                state_d = ST_PC2MAR;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_PC2MAR: begin
                    cnt_d = CNT_LOAD;
                    if (WAIT_CYCLES > 32'd0) begin
                        state_d = ST_MEMWAIT;
                    end else begin
                        state_d = ST_MEM2IR;
                    end
                end
                ST_MEMWAIT: begin
                    // leave on the last wait cycle so MEMWAIT lasts exactly WAIT_CYCLES
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_MEM2IR;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = ST_MEMWAIT;
                    end
                end
                ST_MEM2IR: begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_PC2MAR;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_JUMP:  state_d = ST_JDONE;
                ST_JDONE: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ZERO;
                end
            endcase
        end
    end

    // Moore strobe decode; stall blanks every strobe and done pulse
    always_comb begin
        strb_s = STROBES_OFF;
        sel_s  = IDX_ZERO;
        if (stall) begin
            strb_s = STROBES_OFF;
        end else begin
            case (state_q)
                ST_IDLE: strb_s = STROBES_OFF;
                ST_PC2MAR: begin
                    strb_s.pc_cs  = 1'b1;
                    strb_s.pc_oe  = 1'b1;
                    strb_s.mar_cs = 1'b1;
                    strb_s.mar_we = 1'b1;
                end
                ST_MEMWAIT: strb_s.mem_cs = 1'b1;
                ST_MEM2IR: begin
                    // memory owns the bus here, so the PC counts without driving it
                    strb_s.mem_cs    = 1'b1;
                    strb_s.mem_oe    = 1'b1;
                    strb_s.ir_cs     = 1'b1;
                    strb_s.ir_we     = 1'b1;
                    strb_s.pc_cs     = 1'b1;
                    strb_s.pc_cnt_en = 1'b1;
                    sel_s            = idx_q;
                end
                ST_DONE: strb_s.fetch_done = 1'b1;
                ST_JUMP: begin
                    strb_s.pc_cs  = 1'b1;
                    strb_s.pc_we  = 1'b1;
                    strb_s.opr_oe = 1'b1;
                end
                ST_JDONE: strb_s.jump_done = 1'b1;
                default: strb_s = STROBES_OFF;
            endcase
        end
    end

    assign pc_cs      = strb_s.pc_cs;
    assign pc_oe      = strb_s.pc_oe;
    assign pc_we      = strb_s.pc_we;
    assign pc_cnt_en  = strb_s.pc_cnt_en;
    assign mar_cs     = strb_s.mar_cs;
    assign mar_we     = strb_s.mar_we;
    assign mem_cs     = strb_s.mem_cs;
    assign mem_oe     = strb_s.mem_oe;
    assign ir_cs      = strb_s.ir_cs;
    assign ir_we      = strb_s.ir_we;
    assign ir_sel     = sel_s;
    assign opr_oe     = strb_s.opr_oe;
    assign fetch_done = strb_s.fetch_done;
    assign jump_done  = strb_s.jump_done;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (2 wait states / 1 byte, 0 wait states / 2 bytes)
// on shared stimulus, a directed vector table, corner sequences and a random run.
module tb_fetch_sequencer;

    localparam int WA = 2, NA = 1, WB = 0, NB = 2;

    // {pc_cs,pc_oe,pc_we,pc_cnt_en,mar_cs,mar_we,mem_cs,mem_oe,ir_cs,ir_we,ir_sel,opr_oe,busy,fetch_done,jump_done}
    localparam logic [14:0] W_IDLE    = 15'h0000;
    localparam logic [14:0] W_PC2MAR  = 15'h6604;
    localparam logic [14:0] W_MEMWAIT = 15'h0104;
    localparam logic [14:0] W_MEM2IR  = 15'h49E4;
    localparam logic [14:0] W_SEL1    = 15'h0010;
    localparam logic [14:0] W_DONE    = 15'h0006;
    localparam logic [14:0] W_JUMP    = 15'h500C;
    localparam logic [14:0] W_JDONE   = 15'h0005;
    localparam logic [14:0] W_STALL   = 15'h0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, fetch_req, jump_req, stall;
    int n_checks = 0;
    int n_errors = 0;

    logic a_pc_cs, a_pc_oe, a_pc_we, a_pc_cnt_en, a_mar_cs, a_mar_we, a_mem_cs, a_mem_oe;
    logic a_ir_cs, a_ir_we, a_opr_oe, a_busy, a_fetch_done, a_jump_done;
    logic [0:0] a_ir_sel;
    logic b_pc_cs, b_pc_oe, b_pc_we, b_pc_cnt_en, b_mar_cs, b_mar_we, b_mem_cs, b_mem_oe;
    logic b_ir_cs, b_ir_we, b_opr_oe, b_busy, b_fetch_done, b_jump_done;
    logic [0:0] b_ir_sel;

    fetch_sequencer #(.DATA_WIDTH(8), .WAIT_CYCLES(WA), .IR_BYTES(NA)) u_dut_a (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .jump_req(jump_req), .stall(stall),
        .pc_cs(a_pc_cs), .pc_oe(a_pc_oe), .pc_we(a_pc_we), .pc_cnt_en(a_pc_cnt_en),
        .mar_cs(a_mar_cs), .mar_we(a_mar_we), .mem_cs(a_mem_cs), .mem_oe(a_mem_oe),
        .ir_cs(a_ir_cs), .ir_we(a_ir_we), .ir_sel(a_ir_sel), .opr_oe(a_opr_oe),
        .busy(a_busy), .fetch_done(a_fetch_done), .jump_done(a_jump_done)
    );

    fetch_sequencer #(.DATA_WIDTH(8), .WAIT_CYCLES(WB), .IR_BYTES(NB)) u_dut_b (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .jump_req(jump_req), .stall(stall),
        .pc_cs(b_pc_cs), .pc_oe(b_pc_oe), .pc_we(b_pc_we), .pc_cnt_en(b_pc_cnt_en),
        .mar_cs(b_mar_cs), .mar_we(b_mar_we), .mem_cs(b_mem_cs), .mem_oe(b_mem_oe),
        .ir_cs(b_ir_cs), .ir_we(b_ir_we), .ir_sel(b_ir_sel), .opr_oe(b_opr_oe),
        .busy(b_busy), .fetch_done(b_fetch_done), .jump_done(b_jump_done)
    );

    fetch_sequencer_checker u_chk_a (
        .clk(clk), .reset(reset), .stall(stall), .pc_cs(a_pc_cs), .pc_oe(a_pc_oe), .pc_we(a_pc_we),
        .pc_cnt_en(a_pc_cnt_en), .mar_cs(a_mar_cs), .mar_we(a_mar_we), .mem_cs(a_mem_cs),
        .mem_oe(a_mem_oe), .ir_cs(a_ir_cs), .ir_we(a_ir_we), .opr_oe(a_opr_oe), .busy(a_busy),
        .fetch_done(a_fetch_done), .jump_done(a_jump_done)
    );

    fetch_sequencer_checker u_chk_b (
        .clk(clk), .reset(reset), .stall(stall), .pc_cs(b_pc_cs), .pc_oe(b_pc_oe), .pc_we(b_pc_we),
        .pc_cnt_en(b_pc_cnt_en), .mar_cs(b_mar_cs), .mar_we(b_mar_we), .mem_cs(b_mem_cs),
        .mem_oe(b_mem_oe), .ir_cs(b_ir_cs), .ir_we(b_ir_we), .opr_oe(b_opr_oe), .busy(b_busy),
        .fetch_done(b_fetch_done), .jump_done(b_jump_done)
    );

    wire [14:0] wa = {a_pc_cs, a_pc_oe, a_pc_we, a_pc_cnt_en, a_mar_cs, a_mar_we, a_mem_cs, a_mem_oe,
                      a_ir_cs, a_ir_we, a_ir_sel, a_opr_oe, a_busy, a_fetch_done, a_jump_done};
    wire [14:0] wb = {b_pc_cs, b_pc_oe, b_pc_we, b_pc_cnt_en, b_mar_cs, b_mar_we, b_mem_cs, b_mem_oe,
                      b_ir_cs, b_ir_we, b_ir_sel, b_opr_oe, b_busy, b_fetch_done, b_jump_done};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    // Consumer-side datapath for instance A: PC, MAR, IR latch on the strobes
    logic [7:0] pc_a = 8'h10;
    logic [7:0] mar_a = 8'h00;
    logic [7:0] ir_a = 8'h00;
    wire  [7:0] bus_a = a_pc_oe ? pc_a : a_mem_oe ? mem_f(mar_a) : a_opr_oe ? 8'h3C : 8'h00;

    always @(posedge clk) begin
        if (a_pc_cs && a_pc_we)          pc_a <= bus_a;
        else if (a_pc_cs && a_pc_cnt_en) pc_a <= pc_a + 8'd1;
        if (a_mar_cs && a_mar_we)        mar_a <= bus_a;
        if (a_ir_cs && a_ir_we)          ir_a <= bus_a;
    end

    // Reference model: each accepted request becomes a transaction indexed by cycle k
    bit m_busy [2];
    bit m_jmp  [2];
    int m_k    [2];

    function automatic int w_of(input int d); return (d == 0) ? WA : WB; endfunction
    function automatic int n_of(input int d); return (d == 0) ? NA : NB; endfunction

    function automatic int seq_len(input int w, input int n, input bit jmp);
        return jmp ? 2 : n * (w + 2) + 1;
    endfunction

    function automatic logic [14:0] seq_word(input int w, input int n, input bit jmp, input int k);
        int r;
        int b;
        if (jmp) return (k == 0) ? W_JUMP : W_JDONE;
        if (k >= n * (w + 2)) return W_DONE;
        r = k % (w + 2);
        b = k / (w + 2);
        if (r == 0) return W_PC2MAR;
        if (r <= w) return W_MEMWAIT;
        return (b % 2 == 1) ? (W_MEM2IR | W_SEL1) : W_MEM2IR;
    endfunction

    function automatic logic [14:0] model_out(input int d);
        if (!reset || !m_busy[d]) return W_IDLE;
        if (stall) return W_STALL;
        return seq_word(w_of(d), n_of(d), m_jmp[d], m_k[d]);
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_busy[d] <= 1'b0;
                m_jmp[d]  <= 1'b0;
                m_k[d]    <= 0;
            end else if (!m_busy[d]) begin
                if (jump_req || fetch_req) begin
                    m_busy[d] <= 1'b1;
                    m_jmp[d]  <= jump_req;
                    m_k[d]    <= 0;
                end
            end else if (!stall) begin
                if (m_k[d] + 1 >= seq_len(w_of(d), n_of(d), m_jmp[d])) begin
                    m_busy[d] <= 1'b0;
                    m_k[d]    <= 0;
                end else begin
                    m_k[d] <= m_k[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_a", 32'(wa), 32'(model_out(0)));
        check("model_b", 32'(wb), 32'(model_out(1)));
        check("bus_excl_a", {31'd0, (a_pc_oe & a_mem_oe) | (a_pc_oe & a_opr_oe) | (a_mem_oe & a_opr_oe) | (a_pc_we & a_pc_cnt_en)}, 32'd0);
        check("bus_excl_b", {31'd0, (b_pc_oe & b_mem_oe) | (b_pc_oe & b_opr_oe) | (b_mem_oe & b_opr_oe) | (b_pc_we & b_pc_cnt_en)}, 32'd0);
    end

    typedef struct {
        bit         f;
        bit         j;
        bit         s;
        logic [14:0] exp;
        logic [7:0]  pc;
    } vec_t;

    vec_t tbl [36];
    logic [7:0] pc_hold;
    int na, nb;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, W_IDLE,    8'h10}; tbl[1]  = '{1'b1, 1'b0, 1'b0, W_IDLE,    8'h10};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, W_PC2MAR,  8'h10}; tbl[3]  = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h10};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h10}; tbl[5]  = '{1'b0, 1'b0, 1'b0, W_MEM2IR,  8'h10};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, W_DONE,    8'h11}; tbl[7]  = '{1'b0, 1'b0, 1'b0, W_IDLE,    8'h11};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, W_IDLE,    8'h11}; tbl[9]  = '{1'b0, 1'b0, 1'b0, W_PC2MAR,  8'h11};
        tbl[10] = '{1'b0, 1'b0, 1'b1, W_STALL,   8'h11}; tbl[11] = '{1'b0, 1'b0, 1'b1, W_STALL,   8'h11};
        tbl[12] = '{1'b0, 1'b0, 1'b1, W_STALL,   8'h11}; tbl[13] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h11};
        tbl[14] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h11}; tbl[15] = '{1'b0, 1'b0, 1'b0, W_MEM2IR,  8'h11};
        tbl[16] = '{1'b0, 1'b0, 1'b0, W_DONE,    8'h12}; tbl[17] = '{1'b0, 1'b0, 1'b0, W_IDLE,    8'h12};
        tbl[18] = '{1'b1, 1'b1, 1'b0, W_IDLE,    8'h12}; tbl[19] = '{1'b1, 1'b0, 1'b0, W_JUMP,    8'h12};
        tbl[20] = '{1'b1, 1'b0, 1'b0, W_JDONE,   8'h3C}; tbl[21] = '{1'b1, 1'b0, 1'b0, W_IDLE,    8'h3C};
        tbl[22] = '{1'b0, 1'b0, 1'b0, W_PC2MAR,  8'h3C}; tbl[23] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h3C};
        tbl[24] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h3C}; tbl[25] = '{1'b0, 1'b0, 1'b0, W_MEM2IR,  8'h3C};
        tbl[26] = '{1'b0, 1'b0, 1'b0, W_DONE,    8'h3D}; tbl[27] = '{1'b0, 1'b0, 1'b0, W_IDLE,    8'h3D};
        tbl[28] = '{1'b1, 1'b0, 1'b1, W_IDLE,    8'h3D}; tbl[29] = '{1'b0, 1'b0, 1'b0, W_PC2MAR,  8'h3D};
        tbl[30] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h3D}; tbl[31] = '{1'b0, 1'b0, 1'b0, W_MEMWAIT, 8'h3D};
        tbl[32] = '{1'b0, 1'b0, 1'b0, W_MEM2IR,  8'h3D}; tbl[33] = '{1'b0, 1'b0, 1'b1, W_STALL,   8'h3E};
        tbl[34] = '{1'b0, 1'b0, 1'b0, W_DONE,    8'h3E}; tbl[35] = '{1'b0, 1'b0, 1'b0, W_IDLE,    8'h3E};

        reset = 1'b0; fetch_req = 1'b0; jump_req = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("reset_out_a", 32'(wa), 32'd0);
        check("reset_out_b", 32'(wb), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            fetch_req = tbl[i].f; jump_req = tbl[i].j; stall = tbl[i].s;
            @(negedge clk);
            check($sformatf("vec%0d_out", i), 32'(wa), 32'(tbl[i].exp));
            check($sformatf("vec%0d_pc", i), 32'(pc_a), 32'(tbl[i].pc));
        end
        check("ir_after_table", 32'(ir_a), 32'(mem_f(8'h3D)));

        // Reset asserted mid-MEM2IR: outputs drop at once, PC does not count
        @(posedge clk); #1 fetch_req = 1'b1;
        @(posedge clk); #1 fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_mem2ir", 32'(wa), 32'(W_MEM2IR));
        pc_hold = pc_a;
        #2 reset = 1'b0;
        #1;
        check("async_reset_a", 32'(wa), 32'd0);
        check("async_reset_b", 32'(wb), 32'd0);
        @(posedge clk); #1;
        check("no_pc_count_on_reset", 32'(pc_a), 32'(pc_hold));
        reset = 1'b1;

        // Fresh fetch after reset: done after N*(W+2) edges past the sampling edge
        @(posedge clk); #1 fetch_req = 1'b1;
        pc_hold = pc_a;
        @(posedge clk); #1 fetch_req = 1'b0;
        na = -1; nb = -1;
        for (int c = 0; c < 40 && (na < 0 || nb < 0); c++) begin
            @(negedge clk);
            if (a_fetch_done && na < 0) na = c;
            if (b_fetch_done && nb < 0) nb = c;
            @(posedge clk);
        end
        check("fetch_latency_a", 32'(na), 32'(NA * (WA + 2)));
        check("fetch_latency_b", 32'(nb), 32'(NB * (WB + 2)));
        check("pc_after_refetch", 32'(pc_a), 32'(pc_hold + 8'd1));
        check("ir_after_refetch", 32'(ir_a), 32'(mem_f(pc_hold)));

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            fetch_req = ($urandom_range(0, 2) == 0);
            jump_req  = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 4) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b1; fetch_req = 1'b0; jump_req = 1'b0; stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
